// File: rtl/bit_demux_rx_pkg.sv
// Shared constants for the bit_demux_rx serial channel demultiplexer:
// FSM state encoding, frame marker bits and the channel count.
package bit_demux_rx_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SEL  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_PAR  = 3'd3;
  localparam logic [2:0] ST_STOP = 3'd4;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  localparam int NUM_CH = 4;

endpackage

// File: rtl/bit_demux_shreg.sv
// Enabled left-shift register with synchronous reset; new bits enter at the LSB,
// so a payload sent MSB first lands in natural bit order.
module bit_demux_shreg
  import bit_demux_rx_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              din,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= {q[DATA_W-2:0], din};
    end
  end

endmodule

// File: rtl/bit_demux_rx.sv
// Serial frame receiver that routes a DATA_W payload to one of four channel
// registers. Define BIT_DEMUX_PARITY_EN to add an even-parity bit before stop.
//
// state | meaning
// IDLE  | waiting for a qualified start bit
// SEL   | receiving channel select S1 then S0
// DATA  | shifting payload bits, MSB first
// PAR   | receiving parity bit (BIT_DEMUX_PARITY_EN only)
// STOP  | receiving stop bit; commit payload or flag error
module bit_demux_rx
  import bit_demux_rx_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din,
  input  logic              din_valid,
  output logic [DATA_W-1:0] ch0_q,
  output logic [DATA_W-1:0] ch1_q,
  output logic [DATA_W-1:0] ch2_q,
  output logic [DATA_W-1:0] ch3_q,
  output logic [NUM_CH-1:0] ch_update,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [2:0]        state;
  logic [1:0]        sel;
  logic              sel_phase;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] payload;
  logic              shift_en;
  logic              stop_ok;

`ifdef BIT_DEMUX_PARITY_EN
  logic parity;
  logic par_err;
`endif

  assign busy     = (state != ST_IDLE);
  assign shift_en = din_valid && (state == ST_DATA);

`ifdef BIT_DEMUX_PARITY_EN
  assign stop_ok = (din == STOP_BIT) && !par_err;
`else
  assign stop_ok = (din == STOP_BIT);
`endif

  bit_demux_shreg #(.DATA_W(DATA_W)) u_shreg (
    .clk   (clk),
    .reset (reset),
    .en    (shift_en),
    .din   (din),
    .q     (payload)
  );

  // Bit counter runs down from DATA_W-1; terminal count 0 ends the payload.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      sel       <= '0;
      sel_phase <= 1'b0;
      bit_cnt   <= '0;
      ch0_q     <= '0;
      ch1_q     <= '0;
      ch2_q     <= '0;
      ch3_q     <= '0;
      ch_update <= '0;
      frame_err <= 1'b0;
`ifdef BIT_DEMUX_PARITY_EN
      parity    <= 1'b0;
      par_err   <= 1'b0;
`endif
    end else begin
      ch_update <= '0;
      frame_err <= 1'b0;
      if (din_valid) begin
        case (state)
          ST_IDLE: begin
            if (din == START_BIT) begin
              state     <= ST_SEL;
              sel_phase <= 1'b0;
`ifdef BIT_DEMUX_PARITY_EN
              parity    <= 1'b0;
              par_err   <= 1'b0;
`endif
            end
          end
          ST_SEL: begin
`ifdef BIT_DEMUX_PARITY_EN
            parity <= parity ^ din;
`endif
            if (!sel_phase) begin
              sel[1]    <= din;
              sel_phase <= 1'b1;
            end else begin
              sel[0]    <= din;
              sel_phase <= 1'b0;
              bit_cnt   <= CNT_W'(DATA_W - 1);
              state     <= ST_DATA;
            end
          end
          ST_DATA: begin
`ifdef BIT_DEMUX_PARITY_EN
            parity <= parity ^ din;
`endif
            if (bit_cnt == '0) begin
`ifdef BIT_DEMUX_PARITY_EN
              state <= ST_PAR;
`else
              state <= ST_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
`ifdef BIT_DEMUX_PARITY_EN
          // Mismatch is held until the stop bit so both error kinds share latency.
          ST_PAR: begin
            par_err <= (din != parity);
            state   <= ST_STOP;
          end
`endif
          ST_STOP: begin
            state <= ST_IDLE;
            if (stop_ok) begin
              ch_update <= NUM_CH'(1) << sel;
              case (sel)
                2'd0:    ch0_q <= payload;
                2'd1:    ch1_q <= payload;
                2'd2:    ch2_q <= payload;
                default: ch3_q <= payload;
              endcase
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bit_demux_rx.sv
// Scoreboard bench for bit_demux_rx: frame senders push expected events,
// a negedge monitor pops and compares whenever ch_update or frame_err fires.
module tb_bit_demux_rx;
  localparam int DATA_W = 4;

  logic clk = 1'b0;
  logic reset, din, din_valid;
  logic [DATA_W-1:0] ch0_q, ch1_q, ch2_q, ch3_q;
  logic [3:0] ch_update;
  logic frame_err, busy;

  typedef struct packed {
    logic [3:0]             upd;
    logic                   err;
    logic [3:0][DATA_W-1:0] chv;
  } exp_t;

  exp_t exp_q[$];
  logic [3:0][DATA_W-1:0] model;
  int tests = 0;
  int fails = 0;

  bit_demux_rx #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .ch0_q     (ch0_q),
    .ch1_q     (ch1_q),
    .ch2_q     (ch2_q),
    .ch3_q     (ch3_q),
    .ch_update (ch_update),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic v, input logic b);
    din_valid = v;
    din       = b;
    @(posedge clk);
    #1;
  endtask

  // gap_at >= 0 inserts three unqualified cycles before that payload bit
  task automatic send_frame(input int ch, input logic [DATA_W-1:0] data,
                            input logic stop_b, input logic par_flip, input int gap_at);
    logic [1:0] s;
    logic p;
    exp_t e;
    s = 2'(ch);
    p = s[1] ^ s[0] ^ (^data) ^ par_flip;
    if (stop_b == 1'b0 && par_flip == 1'b0) begin
      model[ch] = data;
      e.upd = 4'b0001 << ch;
      e.err = 1'b0;
    end else begin
      e.upd = 4'b0000;
      e.err = 1'b1;
    end
    e.chv = model;
    exp_q.push_back(e);
    tick(1'b1, 1'b1);
    tick(1'b1, s[1]);
    tick(1'b1, s[0]);
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if ((DATA_W - 1 - i) == gap_at) begin
        for (int g = 0; g < 3; g++) begin
          tick(1'b0, 1'b1);
          check("busy_in_gap", busy, 1'b1);
        end
      end
      tick(1'b1, data[i]);
    end
`ifdef BIT_DEMUX_PARITY_EN
    tick(1'b1, p);
`endif
    tick(1'b1, stop_b);
  endtask

  always @(negedge clk) begin
    if (!reset && (ch_update != 4'b0000 || frame_err)) begin
      tests++;
      if (!((ch_update == 4'b0000) || (!frame_err && $onehot(ch_update)))) begin
        fails++;
        $display("FAIL exclusive_outputs: ch_update=%b frame_err=%b", ch_update, frame_err);
      end
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event: ch_update=%b frame_err=%b, none expected", ch_update, frame_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ch_update", ch_update, e.upd);
        check("frame_err", frame_err, e.err);
        check("ch0_q", ch0_q, e.chv[0]);
        check("ch1_q", ch1_q, e.chv[1]);
        check("ch2_q", ch2_q, e.chv[2]);
        check("ch3_q", ch3_q, e.chv[3]);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_ch_update"}, ch_update, 4'b0000);
    check({tag, "_frame_err"}, frame_err, 1'b0);
    check({tag, "_ch0"}, ch0_q, '0);
    check({tag, "_ch1"}, ch1_q, '0);
    check({tag, "_ch2"}, ch2_q, '0);
    check({tag, "_ch3"}, ch3_q, '0);
  endtask

  initial begin
    model     = '0;
    reset     = 1'b1;
    din       = 1'b0;
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    tick(1'b1, 1'b0);
    check("idle_zero_busy", busy, 1'b0);

    // ch2 payload A, then the same frame with a mid-payload valid gap
    send_frame(2, 4'hA, 1'b0, 1'b0, -1);
    tick(1'b0, 1'b0);
    send_frame(2, 4'hA, 1'b0, 1'b0, 2);
    tick(1'b0, 1'b0);

    send_frame(1, 4'h5, 1'b1, 1'b0, -1);
    tick(1'b0, 1'b0);
    check("idle_after_err", busy, 1'b0);

`ifdef BIT_DEMUX_PARITY_EN
    send_frame(1, 4'h7, 1'b0, 1'b0, -1);
    tick(1'b0, 1'b0);
    send_frame(1, 4'h9, 1'b0, 1'b1, -1);
    tick(1'b0, 1'b0);
    check("idle_after_par_err", busy, 1'b0);
`endif

    // Reset after start, S1, S0 and two payload bits
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    check("busy_before_reset", busy, 1'b1);
    reset = 1'b1;
    tick(1'b1, 1'b1);
    reset = 1'b0;
    model = '0;
    check_all_zero("mid_reset");
    send_frame(1, 4'h6, 1'b0, 1'b0, -1);
    tick(1'b0, 1'b0);

    send_frame(0, 4'h3, 1'b0, 1'b0, -1);
    send_frame(3, 4'hC, 1'b0, 1'b0, -1);
    repeat (4) tick(1'b0, 1'b0);
    check("hold_ch0", ch0_q, 4'h3);
    check("hold_ch1", ch1_q, 4'h6);
    check("hold_ch3", ch3_q, 4'hC);
    check("idle_end", busy, 1'b0);

    check("pending_events", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
